// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: parity modes,
// line-state encodings and the parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Odd parity makes the total number of ones odd; even parity keeps it even.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with an extra wrap bit on each pointer; full/empty are
// registered together with the pointers, and the head word is always on rd_data.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;

    // A push is judged against the registered full flag only, so a pop on
    // the same edge cannot make room for it.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_next = wr_ptr + (AW + 1)'(do_push);
    assign rd_next = rd_ptr + (AW + 1)'(do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            full   <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
            empty  <= (wr_next == rd_next);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small TX FIFO, with a runtime baud divisor and a
// configurable frame format. tx is registered from the FSM state and trails it by one clock.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx
);

    import uart_pkg::*;

    localparam int CNT_W = 4;

    uart_state_e          state;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 par_q;
    logic                 frame_q;
    logic                 bit_done;
    logic                 last_data;
    logic                 last_stop;
    logic                 pop;

    assign bit_done  = (baud_cnt == div_q);
    assign last_data = (bit_cnt == CNT_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == CNT_W'(STOP_BITS - 1));

    // A new frame starts from IDLE or straight out of the final stop bit.
    assign pop  = !empty && ((state == ST_IDLE) || (state == ST_STOP && bit_done && last_stop));
    assign busy = (state != ST_IDLE) || frame_q || !empty;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            frame_q  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            frame_q <= (state != ST_IDLE);
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shift[0];
                ST_PARITY: tx <= par_q;
                default:   tx <= 1'b1;
            endcase

            if (state != ST_IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + DIV_WIDTH'(1);
            end

            case (state)
                ST_IDLE: ;
                ST_START: begin
                    if (bit_done) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift <= shift >> 1;
                        if (last_data) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (last_stop) begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // The divisor is captured here and held for the whole frame.
            if (pop) begin
                state    <= ST_START;
                div_q    <= baud_div;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= head;
                par_q    <= parity_bit(9'(head), PARITY);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances with different frame
// formats, stimulus pushes expected frames, per-instance monitors decode tx.
module tb_uart_tx_fifo;

    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [8:0] data;
        int         div;
        bit         b2b;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic [2:0]  wr_en    = '0;
    logic [7:0]  wr_data  = '0;
    logic [2:0]  full_w;
    logic [2:0]  empty_w;
    logic [2:0]  ovf_w;
    logic [2:0]  busy_w;
    logic [2:0]  tx_w;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ov_cycles[3] = '{0, 0, 0};
    int exp_drops[3] = '{0, 0, 0};
    int last_end[3]  = '{0, 0, 0};
    logic [7:0] burst[8];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .baud_div(baud_div), .wr_en(wr_en[0]), .wr_data(wr_data),
        .full(full_w[0]), .empty(empty_w[0]), .overflow(ovf_w[0]), .busy(busy_w[0]), .tx(tx_w[0]));

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .baud_div(baud_div), .wr_en(wr_en[1]), .wr_data(wr_data),
        .full(full_w[1]), .empty(empty_w[1]), .overflow(ovf_w[1]), .busy(busy_w[1]), .tx(tx_w[1]));

    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .baud_div(baud_div), .wr_en(wr_en[2]), .wr_data(wr_data[6:0]),
        .full(full_w[2]), .empty(empty_w[2]), .overflow(ovf_w[2]), .busy(busy_w[2]), .tx(tx_w[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovf_w[i]) ov_cycles[i] <= ov_cycles[i] + 1;
        end
    end

    function automatic int cfg_bits(input int idx);
        return (idx == 2) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int idx);
        return idx;
    endfunction

    function automatic int cfg_stop(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int idx);
        return 1 + cfg_bits(idx) + ((cfg_par(idx) != 0) ? 1 : 0) + cfg_stop(idx);
    endfunction

    // Expected line levels, bit 0 first: start, data LSB first, parity, stop bits.
    function automatic logic [15:0] frame_bits(input int idx, input logic [8:0] d);
        logic [15:0] f = '1;
        int nb = cfg_bits(idx);
        int ones = $countones(d);
        f[0] = 1'b0;
        for (int i = 0; i < nb; i++) f[1 + i] = d[i];
        if (cfg_par(idx) == 1) f[1 + nb] = (ones % 2 == 0);
        if (cfg_par(idx) == 2) f[1 + nb] = (ones % 2 == 1);
        return f;
    endfunction

    function automatic void q_push(input int idx, input exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic bit q_pop(input int idx, output exp_t e);
        bit ok = 1'b0;
        e = '{data: '0, div: 0, b2b: 1'b0};
        case (idx)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
        return ok;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Consumes one frame whose first start-bit sample has just been taken.
    task automatic check_frame(input int idx);
        exp_t        e;
        logic [15:0] f;
        int          len;
        int          per;
        int          start_cyc;
        int          bad_b = 0;
        int          bad_s = 0;
        logic        bad_got = 1'b0;
        bit          ok = 1'b1;
        start_cyc = cyc;
        if (!q_pop(idx, e)) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_frame dut%0d: got start bit at cycle %0d, expected idle line", idx, cyc);
            return;
        end
        f   = frame_bits(idx, e.data);
        len = frame_len(idx);
        per = e.div + 1;
        for (int b = 0; b < len; b++) begin
            for (int s = 0; s < per; s++) begin
                if (b != 0 || s != 0) begin
                    @(negedge clk);
                    if (rst) return;
                end
                if (ok && tx_w[idx] !== f[b]) begin
                    ok      = 1'b0;
                    bad_b   = b;
                    bad_s   = s;
                    bad_got = tx_w[idx];
                end
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL frame dut%0d data=%h div=%0d: bit %0d sample %0d got %b, expected %b",
                     idx, e.data, e.div, bad_b, bad_s, bad_got, f[bad_b]);
        end
        if (e.b2b) begin
            tests++;
            if (start_cyc != last_end[idx] + 1) begin
                fails++;
                $display("[TB] FAIL back_to_back dut%0d: start at cycle %0d, expected %0d",
                         idx, start_cyc, last_end[idx] + 1);
            end
        end
        last_end[idx] = cyc;
    endtask

    task automatic run_monitor(input int idx);
        logic prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !tx_w[idx]) begin
                check_frame(idx);
                prev = 1'b1;
            end else begin
                prev = tx_w[idx];
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);
    initial run_monitor(2);

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) burst[k] = 8'($urandom);
    endtask

    // Burst from an idle instance: the first byte leaves the FIFO on the next
    // edge, so DEPTH+1 consecutive writes fit while the first frame is on the line.
    task automatic applyStimulus(input int idx, input int n, input int div_first, input int div_rest);
        int   accepted = (n < FIFO_DEPTH + 1) ? n : FIFO_DEPTH + 1;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (k < accepted) begin
                e.data = 9'(burst[k]) & ((idx == 2) ? 9'h07F : 9'h0FF);
                e.div  = (k == 0) ? div_first : div_rest;
                e.b2b  = (k > 0);
                q_push(idx, e);
            end
            wr_data    = burst[k];
            wr_en[idx] = 1'b1;
            @(negedge clk);
        end
        wr_en = '0;
        exp_drops[idx] += n - accepted;
    endtask

    task automatic wait_idle(input string what);
        int n = 0;
        @(negedge clk);
        while (busy_w != 3'b000 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy_w != 3'b000) begin
            tests++;
            fails++;
            $display("[TB] FAIL idle_timeout %s: busy=%b, expected 000", what, busy_w);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx_low(input int idx, input int limit, output int k);
        k = 0;
        while (tx_w[idx] !== 1'b0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (tx_w[idx] !== 1'b0) begin
            tests++;
            fails++;
            $display("[TB] FAIL tx_low_timeout dut%0d: tx=%b, expected 0", idx, tx_w[idx]);
        end
    endtask

    initial begin
        int k;
        int m;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_tx", int'(tx_w[0]), 1);
        checkOutput("reset_busy", int'(busy_w[0]), 0);
        checkOutput("reset_full", int'(full_w[0]), 0);
        checkOutput("reset_empty", int'(empty_w), 7);
        checkOutput("reset_overflow", int'(ovf_w[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5, 8N1, 4 clk per bit: latency and busy window
        baud_div = 16'd3;
        burst[0] = 8'hA5;
        applyStimulus(0, 1, 3, 3);
        wait_tx_low(0, 10, k);
        checkOutput("start_latency", k, 2);
        m = 0;
        while (busy_w[0] && m < 200) begin
            @(negedge clk);
            m++;
        end
        checkOutput("busy_after_start", m, 40);
        wait_idle("single_a5");

        // Odd parity with two stop bits, even parity on a 7-bit frame
        baud_div = 16'd1;
        burst[0] = 8'h03;
        applyStimulus(1, 1, 1, 1);
        wait_idle("odd_03");
        burst[0] = 8'h03;
        applyStimulus(2, 1, 1, 1);
        wait_idle("even_03");
        fill_random(3);
        applyStimulus(1, 3, 1, 1);
        wait_idle("odd_burst");

        // Five consecutive writes fit without overflow
        baud_div = 16'd2;
        fill_random(5);
        applyStimulus(0, 5, 2, 2);
        checkOutput("no_overflow_5", ov_cycles[0], 0);
        wait_idle("burst5");

        // One more write into a full FIFO is dropped with a single-cycle pulse
        baud_div = 16'd3;
        fill_random(5);
        applyStimulus(0, 5, 3, 3);
        checkOutput("full_before_drop", int'(full_w[0]), 1);
        wr_data  = 8'($urandom);
        wr_en[0] = 1'b1;
        @(negedge clk);
        wr_en = '0;
        exp_drops[0]++;
        checkOutput("overflow_pulse", int'(ovf_w[0]), 1);
        @(negedge clk);
        checkOutput("overflow_clear", int'(ovf_w[0]), 0);
        wait_idle("overflow");

        // Reset in the middle of data bit 3
        fill_random(1);
        applyStimulus(0, 1, 3, 3);
        wait_tx_low(0, 10, k);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midframe_rst_tx", int'(tx_w[0]), 1);
        checkOutput("midframe_rst_empty", int'(empty_w[0]), 1);
        checkOutput("midframe_rst_busy", int'(busy_w[0]), 0);
        checkOutput("midframe_rst_full", int'(full_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        fill_random(1);
        applyStimulus(0, 1, 3, 3);
        wait_idle("after_reset");

        // Divisor change mid-frame only affects the following frame
        fill_random(2);
        applyStimulus(0, 2, 3, 7);
        wait_tx_low(0, 10, k);
        repeat (6) @(negedge clk);
        baud_div = 16'd7;
        wait_idle("div_change");
        baud_div = 16'd0;
        fill_random(1);
        applyStimulus(0, 1, 0, 0);
        wait_idle("div_zero");

        for (int it = 0; it < 12; it++) begin
            int idx = int'($urandom_range(0, 2));
            int dv  = int'($urandom_range(0, 3));
            int n   = int'($urandom_range(1, 7));
            baud_div = 16'(dv);
            fill_random(n);
            applyStimulus(idx, n, dv, dv);
            wait_idle("random");
        end

        wait_idle("final");
        checkOutput("drain_q0", q0.size(), 0);
        checkOutput("drain_q1", q1.size(), 0);
        checkOutput("drain_q2", q2.size(), 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("overflow_count_dut%0d", i), ov_cycles[i], exp_drops[i]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
